// File: rtl/kbd_matrix_injector.sv
// Scripted keyboard source for the C64 keyboard matrix.
// Key codes are queued in a FIFO and typed one at a time. Each key is held for
// HOLD_CYCLES and then released for GAP_CYCLES. The matrix scan is answered
// combinationally from the currently pressed key.
module kbd_matrix_injector #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned HOLD_CYCLES = 400000,
    parameter int unsigned GAP_CYCLES  = 400000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [6:0]                    key_code,
    input  logic                          key_valid,
    output logic                          key_ready,
    input  logic [7:0]                    keyboard_ROW,
    output logic [7:0]                    keyboard_COL,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [6:0]       PauseCode = 7'h7F;
    localparam logic [CNT_W-1:0] HoldLoad  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GapLoad   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [AW:0]      FullLevel = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StPress, StRelease} state_e;

    logic [6:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic             push, pop;
    logic [6:0]       head;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Pressed set: at most one matrix key plus the left shift key.
    logic             key_on_q, key_on_d;
    logic [2:0]       key_row_q, key_row_d;
    logic [2:0]       key_col_q, key_col_d;
    logic             shift_on_q, shift_on_d;

    assign key_ready = (level_q != FullLevel);
    assign push      = key_valid && key_ready;
    assign head      = mem_q[rd_ptr_q];
    assign level     = level_q;
    assign busy      = (level_q != '0) || (state_q != StIdle);

    // FIFO storage; data needs no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= key_code;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   level_q <= level_q + (AW + 1)'(1);
                2'b01:   level_q <= level_q - (AW + 1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // FSM state, hold/gap counter and pressed set registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            key_on_q   <= 1'b0;
            key_row_q  <= '0;
            key_col_q  <= '0;
            shift_on_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_on_q   <= key_on_d;
            key_row_q  <= key_row_d;
            key_col_q  <= key_col_d;
            shift_on_q <= shift_on_d;
        end
    end

    // Next-state: pop a code in idle, hold it, then release for the gap.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        key_on_d   = key_on_q;
        key_row_d  = key_row_q;
        key_col_d  = key_col_q;
        shift_on_d = shift_on_q;
        pop        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (level_q != '0) begin
                    pop = 1'b1;
                    if (head == PauseCode) begin
                        // Pause token occupies a full key slot with nothing pressed.
                        key_on_d   = 1'b0;
                        shift_on_d = 1'b0;
                    end else begin
                        key_on_d   = 1'b1;
                        key_row_d  = head[5:3];
                        key_col_d  = head[2:0];
                        shift_on_d = head[6];
                    end
                    cnt_d   = HoldLoad;
                    state_d = StPress;
                end
            end
            StPress: begin
                if (cnt_q == '0) begin
                    key_on_d   = 1'b0;
                    shift_on_d = 1'b0;
                    cnt_d      = GapLoad;
                    state_d    = StRelease;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StRelease: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Matrix response: a pressed key pulls its column low when its row is selected.
    always_comb begin
        keyboard_COL = 8'hFF;
        if (key_on_q && !keyboard_ROW[key_row_q]) begin
            keyboard_COL[key_col_q] = 1'b0;
        end
        // Left shift lives at row 1, column 7.
        if (shift_on_q && !keyboard_ROW[1]) begin
            keyboard_COL[7] = 1'b0;
        end
    end

endmodule

// File: doc/kbd_matrix_injector.md
Name: kbd_matrix_injector

Overview:
- Scripted keyboard source for the C64 keyboard matrix.
- Accepts a stream of key codes through a FIFO and "types" them, one at a time, into the matrix: each key is pressed for a programmable time, then released for a programmable gap.
- Answers the c64 matrix scan: the c64 drives keyboard_ROW and reads back keyboard_COL, so the block replaces the constant all-ones column tie-off.
- Used by benches and board tops to auto-type commands such as LOAD"$",8.

Parameters:
FIFO_DEPTH, 16, key FIFO entries; power of two, minimum 2
CNT_W, 24, width of hold/gap counter
HOLD_CYCLES, 400000, clk cycles a key stays pressed; 1 to 2^CNT_W-1
GAP_CYCLES, 400000, clk cycles all keys released after a press; 1 to 2^CNT_W-1

Ports:
clk  in  1  clock, same domain as the c64 dot clock
reset  in  1  synchronous, active-high
key_code  in  7  [5:3] row index, [2:0] column index, [6] also press left shift (row 1, col 7); 7'h7F = pause token
key_valid  in  1  key_code valid
key_ready  out  1  FIFO not full
keyboard_ROW  in  8  active-low row select driven by c64
keyboard_COL  out  8  active-low column response to c64
busy  out  1  FIFO non-empty or FSM not IDLE
level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
Reset values (on the next clk edge with reset=1):
- FIFO empty; level=0; key_ready=1; busy=0.
- FSM in IDLE; counter 0; pressed set empty, so keyboard_COL=8'hFF.
- Reset during PRESS drops the key immediately; queued keys are discarded.

Input handshake:
- A write occurs on an edge where key_valid && key_ready. key_ready = !full, registered from level.
- A write while full is ignored.
- Pop and write in the same cycle are both performed; level is unchanged.
- Pointers wrap modulo FIFO_DEPTH.

FSM states: IDLE, PRESS, RELEASE.
- IDLE:
  - If the FIFO is non-empty, pop the head and load the pressed set. Normal code: key (row,col), plus (1,7) if bit6=1. Code 7'h7F: empty set.
  - Load counter with HOLD_CYCLES-1 and go to PRESS.
  - If the FIFO is empty, stay in IDLE.
- PRESS: decrement the counter each cycle. At 0, clear the pressed set, load GAP_CYCLES-1 and go to RELEASE.
- RELEASE: decrement the counter each cycle. At 0, go to IDLE.

Timing:
- A key written at edge N is popped at edge N+1 if the FSM is idle. Its press is visible on keyboard_COL from cycle N+2, for exactly HOLD_CYCLES cycles.
- Press-to-press period for back-to-back keys is HOLD_CYCLES+GAP_CYCLES+1 cycles.

Matrix response:
- Combinational from keyboard_ROW and the registered pressed set.
- keyboard_COL[c]=0 iff a pressed key (r,c) has keyboard_ROW[r]=0.
- Several ROW bits low at once return the AND of their columns (multi-row scan).
- ROW=8'hFF returns 8'hFF.
- No ghosting emulation.

busy = (level!=0) || (state!=IDLE).

Test Plan:
- Reset, then write 7'h0A; with ROW=8'hFD: COL=8'hFB from cycle N+2 for HOLD_CYCLES cycles, then 8'hFF. With ROW=8'hFE throughout: COL=8'hFF throughout.
- Write 7'h4A, ROW=8'hFD -> COL=8'h7B during PRESS. ROW=8'h00 -> COL=8'h7B. ROW=8'hFB -> COL=8'hFF.
- Overfill: HOLD_CYCLES=GAP_CYCLES=4, write 20 codes back-to-back.
  - key_ready drops when level=16; writes while full are ignored.
  - The bench re-offers each refused code until it is accepted.
  - Press sequence on COL matches write order, period 9 cycles.
- Pause token: write 7'h0A, 7'h7F, 7'h0A -> second press starts 2*(HOLD+GAP+1) cycles after the first; COL stays 8'hFF during the pause slot; busy=1 throughout.
- Reset asserted mid-PRESS with 3 keys queued -> next cycle COL=8'hFF, level=0, busy=0, key_ready=1. No further presses appear.
- Simultaneous write and pop at level=1 while the FSM returns to IDLE -> level stays 1 and no entry is lost (checked by count of presses).
